prim_clock_switch_ctrl: RTL and testbench
=========================================

Name: prim_clock_switch_ctrl

Overview:
Sequencer that drives the select input of a 2:1 clock mux primitive and the enable of its downstream clock gate. It switches between two clock sources without glitches: gate the output off, wait, change the select, wait for the target source to be reported alive, then re-enable. It runs in a single always-on clock domain; the mux and gate sit outside this block.

Parameters:
GateCycles, 4, cycles clk_en_o stays low before sel_o changes (min 1)
SettleCycles, 4, cycles after sel_o changes before clk_en_o may rise (min 1)
TimeoutCycles, 256, max cycles to wait for target-alive before abort (min 2)
CntW, 9, counter width; must hold max(GateCycles, SettleCycles, TimeoutCycles)
ResetSel, 1'b0, sel_o value out of reset

Ports:
clk_i  in  1  always-on control clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  switch request valid
req_sel_i  in  1  requested source (0=clk0, 1=clk1)
req_ready_o  out  1  high in IDLE only
clk0_alive_i  in  1  clk0 source running (already synchronised into clk_i)
clk1_alive_i  in  1  clk1 source running (already synchronised into clk_i)
sel_o  out  1  to mux sel_i
clk_en_o  out  1  to output clock gate enable
busy_o  out  1  high in any state other than IDLE
done_o  out  1  one-cycle pulse when a switch completes or aborts
err_o  out  1  sticky timeout flag; cleared by the next accepted request

Behaviour:
- Reset (async assert, sync deassert by the integrator): state=IDLE, sel_o=ResetSel, clk_en_o=1, req_ready_o=1, busy_o=0, done_o=0, err_o=0, counter=0.
- All outputs are registered. There is no combinational path from any input to any output.
- IDLE: req_ready_o=1. On req_valid_i&&req_ready_o, latch req_sel_i as tgt and clear err_o.
  - If tgt==sel_o: go to DONE (no gating; done pulse 1 cycle after acceptance).
  - Otherwise go to GATE: clk_en_o=0 in the cycle after acceptance, counter loaded.
- GATE: clk_en_o=0. Stays exactly GateCycles cycles, then goes to SWITCH.
- SWITCH: single cycle. sel_o<=tgt, counter reloaded, go to SETTLE.
- SETTLE: clk_en_o=0. Leaves only after both hold:
  - SettleCycles have elapsed since SWITCH;
  - the alive input of tgt has been high for one sampled cycle.
  - On success: go to ENABLE.
  - Timeout counter starts in SWITCH. If the wait reaches TimeoutCycles: set err_o, sel_o<=~tgt (revert), go to ENABLE.
- ENABLE: clk_en_o<=1, go to DONE.
- DONE: done_o=1 for exactly one cycle, return to IDLE.
- Successful switch latency, acceptance to done_o: GateCycles+SettleCycles+3 cycles when the target is already alive.
- While busy, req_valid_i is ignored (ready=0); the requester must hold valid. There are no queued requests.
- A request arriving in the same cycle as the done pulse is not accepted; it is accepted the following cycle in IDLE.
- If the target's alive input drops during SETTLE, the elapsed-time check continues but the alive condition restarts.
- The revert path on timeout does not wait for the original clock's alive signal (it was running before the switch).
- Reset asserted mid-sequence: immediate return to reset values, i.e. sel_o=ResetSel and clk_en_o=1. The integrator guarantees clocks are quiescent under reset.
- Counters saturate; they never wrap.

Decomposition:
- Shared package prim_clock_switch_pkg:
  - state enum typedef (IDLE, GATE, SWITCH, SETTLE, ENABLE, DONE), with explicit encoding;
  - localparam defaults.
- One natural sub-module, prim_clock_switch_cnt: a loadable saturating down-counter with zero flag, used for both the gate/settle timing and the timeout.
- The FSM stays in the top module.

Test Plan:
- Reset release, no requests: sel_o=0, clk_en_o=1, req_ready_o=1, busy_o=0 held for 20 cycles.
- Request sel=1, clk1_alive_i=1, defaults: clk_en_o falls 1 cycle after acceptance; sel_o=1 at cycle 6; clk_en_o=1 and done_o pulse at cycle 11; err_o=0.
- Request sel=1 with clk1_alive_i rising 30 cycles after acceptance: clk_en_o stays 0 until alive is seen, done_o pulses 3 cycles after alive is sampled; sel_o=1.
- Request sel=1 with clk1_alive_i=0 throughout, TimeoutCycles=16: err_o=1, sel_o reverts to 0, clk_en_o=1, single done_o pulse.
- Request the current source (sel=0 while sel_o=0): clk_en_o never drops, done_o pulses 1 cycle after acceptance.
- Assert rst_ni during SETTLE: sel_o returns to 0 and clk_en_o to 1 asynchronously; a new request after release completes normally. Also assert that clk_en_o is 0 in every cycle where sel_o changes.

Source files
------------

// File: rtl/prim_clock_switch_pkg.sv
// Shared types and defaults for the glitch-free clock switch sequencer.
// Provides the FSM state encoding and the default timing parameters.
package prim_clock_switch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_GATE   = 3'd1,
      ST_SWITCH = 3'd2,
      ST_SETTLE = 3'd3,
      ST_ENABLE = 3'd4,
      ST_DONE   = 3'd5
   } sw_state_e;

   localparam int unsigned GateCyclesDef    = 4;
   localparam int unsigned SettleCyclesDef  = 4;
   localparam int unsigned TimeoutCyclesDef = 256;
   localparam int unsigned CntWDef          = 9;
   localparam logic        ResetSelDef      = 1'b0;

endpackage

// File: rtl/prim_clock_switch_cnt.sv
// Loadable saturating down-counter with zero flag.
// Ports: clk_i/rst_ni clock and async active-low reset; load_i/load_val_i
// load a new value (wins over decrement); dec_i decrements, holding at zero;
// zero_o is high while the count is zero.
module prim_clock_switch_cnt #(
   parameter int unsigned CntW = 9
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            load_i,
   input  logic [CntW-1:0] load_val_i,
   input  logic            dec_i,
   output logic            zero_o
);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Next count: load has priority, decrement stops at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/prim_clock_switch_ctrl.sv
// Sequencer for a 2:1 clock mux and its downstream clock gate. A switch
// gates the output, waits, flips the mux select, waits for the new source
// to be alive (or times out and reverts), then re-enables the gate.
// Ports: clk_i/rst_ni always-on clock and async active-low reset;
// req_valid_i/req_sel_i/req_ready_o switch request handshake;
// clk0_alive_i/clk1_alive_i synchronised source-running flags;
// sel_o mux select; clk_en_o gate enable; busy_o sequence in progress;
// done_o one-cycle completion pulse; err_o sticky timeout flag.
module prim_clock_switch_ctrl
   import prim_clock_switch_pkg::*;
#(
   parameter int unsigned GateCycles    = GateCyclesDef,
   parameter int unsigned SettleCycles  = SettleCyclesDef,
   parameter int unsigned TimeoutCycles = TimeoutCyclesDef,
   parameter int unsigned CntW          = CntWDef,
   parameter logic        ResetSel      = ResetSelDef
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic req_valid_i,
   input  logic req_sel_i,
   output logic req_ready_o,
   input  logic clk0_alive_i,
   input  logic clk1_alive_i,
   output logic sel_o,
   output logic clk_en_o,
   output logic busy_o,
   output logic done_o,
   output logic err_o
);

   // Counters reach zero after N-1 decrements, so a state held "until zero"
   // lasts exactly N cycles.
   localparam logic [CntW-1:0] GateLoad    = CntW'(GateCycles - 1);
   localparam logic [CntW-1:0] SettleLoad  = CntW'(SettleCycles - 1);
   localparam logic [CntW-1:0] TimeoutLoad = CntW'(TimeoutCycles - 1);

   sw_state_e state_q, state_d;
   logic sel_q, sel_d;
   logic clk_en_q, clk_en_d;
   logic ready_q, ready_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic err_q, err_d;
   logic tgt_q, tgt_d;
   logic alive_q, alive_d;

   logic            tmr_load, tmr_dec, tmr_zero;
   logic [CntW-1:0] tmr_val;
   logic            to_load, to_dec, to_zero;

   // Gate-hold and settle timing.
   prim_clock_switch_cnt #(.CntW(CntW)) u_tmr (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .dec_i      (tmr_dec),
      .zero_o     (tmr_zero)
   );

   // Wait-for-alive timeout, started in SWITCH.
   prim_clock_switch_cnt #(.CntW(CntW)) u_to (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (to_load),
      .load_val_i (TimeoutLoad),
      .dec_i      (to_dec),
      .zero_o     (to_zero)
   );

   // Target alive flag, sampled once so SETTLE sees a registered value;
   // a drop clears it, which restarts the alive condition.
   assign alive_d = tgt_q ? clk1_alive_i : clk0_alive_i;

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      clk_en_d = clk_en_q;
      ready_d  = ready_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = err_q;
      tgt_d    = tgt_q;
      tmr_load = 1'b0;
      tmr_val  = GateLoad;
      tmr_dec  = 1'b0;
      to_load  = 1'b0;
      to_dec   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid_i && ready_q) begin
               tgt_d   = req_sel_i;
               err_d   = 1'b0;
               ready_d = 1'b0;
               busy_d  = 1'b1;
               if (req_sel_i == sel_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d  = ST_GATE;
                  clk_en_d = 1'b0;
                  tmr_load = 1'b1;
                  tmr_val  = GateLoad;
               end
            end
         end
         ST_GATE: begin
            if (tmr_zero) begin
               state_d = ST_SWITCH;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ST_SWITCH: begin
            sel_d    = tgt_q;
            tmr_load = 1'b1;
            tmr_val  = SettleLoad;
            to_load  = 1'b1;
            state_d  = ST_SETTLE;
         end
         ST_SETTLE: begin
            tmr_dec = 1'b1;
            to_dec  = 1'b1;
            if (tmr_zero && alive_q) begin
               state_d = ST_ENABLE;
            end else if (to_zero) begin
               // Revert without waiting: the original source was running.
               err_d   = 1'b1;
               sel_d   = ~tgt_q;
               state_d = ST_ENABLE;
            end
         end
         ST_ENABLE: begin
            clk_en_d = 1'b1;
            done_d   = 1'b1;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d  = ST_IDLE;
            clk_en_d = 1'b1;
            ready_d  = 1'b1;
            busy_d   = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         sel_q    <= ResetSel;
         clk_en_q <= 1'b1;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         tgt_q    <= ResetSel;
         alive_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         clk_en_q <= clk_en_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         tgt_q    <= tgt_d;
         alive_q  <= alive_d;
      end
   end

   assign sel_o       = sel_q;
   assign clk_en_o    = clk_en_q;
   assign req_ready_o = ready_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_prim_clock_switch_ctrl.sv
// Directed bench for prim_clock_switch_ctrl: default-parameter instance for
// normal switching, plus a short-timeout instance for the abort path.
module tb_prim_clock_switch_ctrl;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   logic req_valid = 1'b0;
   logic req_valid_t = 1'b0;
   logic req_sel = 1'b0;
   logic clk0_alive = 1'b1;
   logic clk1_alive = 1'b1;

   logic ready, sel, clk_en, busy, done, err;
   logic ready_t, sel_t, clk_en_t, busy_t, done_t, err_t;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   prim_clock_switch_ctrl dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_valid_i  (req_valid),
      .req_sel_i    (req_sel),
      .req_ready_o  (ready),
      .clk0_alive_i (clk0_alive),
      .clk1_alive_i (clk1_alive),
      .sel_o        (sel),
      .clk_en_o     (clk_en),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err)
   );

   prim_clock_switch_ctrl #(.TimeoutCycles(16)) dut_t (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_valid_i  (req_valid_t),
      .req_sel_i    (req_sel),
      .req_ready_o  (ready_t),
      .clk0_alive_i (clk0_alive),
      .clk1_alive_i (clk1_alive),
      .sel_o        (sel_t),
      .clk_en_o     (clk_en_t),
      .busy_o       (busy_t),
      .done_o       (done_t),
      .err_o        (err_t)
   );

   // The gate must be off whenever the select moves (outside reset).
   logic rst_prev = 1'b0;
   logic sel_prev = 1'b0;
   logic sel_t_prev = 1'b0;
   always @(negedge clk_i) begin
      if (rst_ni && rst_prev) begin
         if (sel !== sel_prev) begin
            n_vec++;
            if (clk_en !== 1'b0) begin
               n_err++;
               $display("FAIL sel_change_gated: clk_en=%b required 0", clk_en);
            end
         end
         if (sel_t !== sel_t_prev) begin
            n_vec++;
            if (clk_en_t !== 1'b0) begin
               n_err++;
               $display("FAIL sel_change_gated_t: clk_en=%b required 0", clk_en_t);
            end
         end
      end
      rst_prev   = rst_ni;
      sel_prev   = sel;
      sel_t_prev = sel_t;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic request(input logic s);
      req_sel = s;
      req_valid = 1'b1;
      n_vec++;
      if (ready !== 1'b1) begin
         n_err++;
         $display("FAIL req_ready: got %b required 1", ready);
      end
      tick();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [5:0] idle_v;
      rst_ni = 1'b0;
      repeat (3) tick();
      idle_v = {sel, clk_en, ready, busy, done, err};
      n_vec++;
      if (idle_v !== 6'b011000) begin
         n_err++;
         $display("FAIL reset_values: got %b required 011000", idle_v);
      end
      rst_ni = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         idle_v = {sel, clk_en, ready, busy, done, err};
         n_vec++;
         if (idle_v !== 6'b011000) begin
            n_err++;
            $display("FAIL idle_hold cyc%0d: got %b required 011000", k, idle_v);
         end
      end
   endtask

   task automatic test_switch();
      request(1'b1);
      n_vec++;
      if ({clk_en, busy, ready} !== 3'b010) begin
         n_err++;
         $display("FAIL switch_accept: got %b required 010", {clk_en, busy, ready});
      end
      for (int k = 1; k <= 11; k++) begin
         tick();
         if (k == 4) begin
            n_vec++;
            if ({sel, clk_en} !== 2'b00) begin
               n_err++;
               $display("FAIL switch_gate_end: got %b required 00", {sel, clk_en});
            end
         end
         if (k == 5) begin
            n_vec++;
            if ({sel, clk_en} !== 2'b10) begin
               n_err++;
               $display("FAIL switch_sel: got %b required 10", {sel, clk_en});
            end
         end
         if (k == 9) begin
            n_vec++;
            if ({clk_en, done} !== 2'b00) begin
               n_err++;
               $display("FAIL switch_settle: got %b required 00", {clk_en, done});
            end
         end
         if (k == 10) begin
            n_vec++;
            if ({clk_en, done, err, sel} !== 4'b1101) begin
               n_err++;
               $display("FAIL switch_done: got %b required 1101", {clk_en, done, err, sel});
            end
         end
         if (k == 11) begin
            n_vec++;
            if ({done, ready, busy} !== 3'b010) begin
               n_err++;
               $display("FAIL switch_idle: got %b required 010", {done, ready, busy});
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      // Same-source request, then a new request held through the done pulse.
      req_sel = 1'b1;
      req_valid = 1'b1;
      tick();
      n_vec++;
      if ({done, clk_en, busy, ready} !== 4'b1110) begin
         n_err++;
         $display("FAIL same_src_done: got %b required 1110", {done, clk_en, busy, ready});
      end
      req_sel = 1'b0;
      tick();
      n_vec++;
      if ({done, ready, busy, clk_en} !== 4'b0101) begin
         n_err++;
         $display("FAIL b2b_not_taken: got %b required 0101", {done, ready, busy, clk_en});
      end
      tick();
      req_valid = 1'b0;
      n_vec++;
      if ({clk_en, busy} !== 2'b01) begin
         n_err++;
         $display("FAIL b2b_taken: got %b required 01", {clk_en, busy});
      end
      repeat (10) tick();
      n_vec++;
      if ({done, sel, clk_en} !== 3'b101) begin
         n_err++;
         $display("FAIL b2b_done: got %b required 101", {done, sel, clk_en});
      end
      tick();
   endtask

   task automatic test_reset_mid();
      clk1_alive = 1'b0;
      request(1'b1);
      repeat (7) tick();
      n_vec++;
      if ({sel, clk_en, busy} !== 3'b101) begin
         n_err++;
         $display("FAIL mid_settle: got %b required 101", {sel, clk_en, busy});
      end
      #2 rst_ni = 1'b0;
      #1;
      n_vec++;
      if ({sel, clk_en, ready, busy} !== 4'b0110) begin
         n_err++;
         $display("FAIL async_reset: got %b required 0110", {sel, clk_en, ready, busy});
      end
      tick();
      rst_ni = 1'b1;
      clk1_alive = 1'b1;
      tick();
      request(1'b1);
      repeat (10) tick();
      n_vec++;
      if ({done, sel, clk_en, err} !== 4'b1110) begin
         n_err++;
         $display("FAIL post_reset_done: got %b required 1110", {done, sel, clk_en, err});
      end
      tick();
   endtask

   task automatic test_alive_late();
      clk0_alive = 1'b0;
      request(1'b0);
      for (int k = 1; k <= 31; k++) begin
         tick();
         n_vec++;
         if ({clk_en, done} !== 2'b00) begin
            n_err++;
            $display("FAIL alive_wait cyc%0d: got %b required 00", k, {clk_en, done});
         end
         if (k == 29) clk0_alive = 1'b1;
      end
      tick();
      n_vec++;
      if ({clk_en, done, sel, err} !== 4'b1100) begin
         n_err++;
         $display("FAIL alive_done: got %b required 1100", {clk_en, done, sel, err});
      end
      tick();
   endtask

   task automatic test_timeout();
      clk1_alive = 1'b0;
      req_sel = 1'b1;
      req_valid_t = 1'b1;
      tick();
      req_valid_t = 1'b0;
      for (int k = 1; k <= 23; k++) begin
         tick();
         if (k == 20) begin
            n_vec++;
            if ({sel_t, clk_en_t, err_t, done_t} !== 4'b1000) begin
               n_err++;
               $display("FAIL to_waiting: got %b required 1000", {sel_t, clk_en_t, err_t, done_t});
            end
         end
         if (k == 21) begin
            n_vec++;
            if ({sel_t, clk_en_t, err_t, done_t} !== 4'b0010) begin
               n_err++;
               $display("FAIL to_revert: got %b required 0010", {sel_t, clk_en_t, err_t, done_t});
            end
         end
         if (k == 22) begin
            n_vec++;
            if ({sel_t, clk_en_t, err_t, done_t} !== 4'b0111) begin
               n_err++;
               $display("FAIL to_done: got %b required 0111", {sel_t, clk_en_t, err_t, done_t});
            end
         end
         if (k == 23) begin
            n_vec++;
            if ({sel_t, clk_en_t, err_t, done_t, ready_t} !== 5'b01101) begin
               n_err++;
               $display("FAIL to_sticky: got %b required 01101",
                        {sel_t, clk_en_t, err_t, done_t, ready_t});
            end
         end
      end
      req_sel = 1'b0;
      req_valid_t = 1'b1;
      tick();
      req_valid_t = 1'b0;
      n_vec++;
      if ({err_t, done_t} !== 2'b01) begin
         n_err++;
         $display("FAIL to_err_clear: got %b required 01", {err_t, done_t});
      end
      clk1_alive = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_switch();
      test_back_to_back();
      test_reset_mid();
      test_alive_late();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
